// File: rtl/rx_prbs_sampler.sv
// ============================================================================
// Module   : rx_prbs_sampler
// Purpose  : Receive-side decimating slicer and self-synchronising PRBS9
//            checker. Keeps one sample out of every OS at a selectable phase,
//            slices it on its sign bit, then locks a PRBS9 (x^9+x^5+1)
//            checker onto the bit stream and accumulates bit and error
//            counts for BER measurement.
// Ports    : clock        - system clock
//            i_reset      - asynchronous active-low reset
//            i_enable     - sample valid / clock enable (0 freezes state)
//            i_clear      - synchronous counter clear (RX_BER_CLEAR_EN only)
//            i_data       - signed filtered sample, one per enabled cycle
//            i_phase      - decimation phase to keep
//            o_bit        - sliced bit (negative sample -> 1)
//            o_bit_valid  - one-cycle strobe qualifying o_bit
//            o_locked     - checker is in the CHECK state
//            o_bit_count  - bits checked while locked (saturating)
//            o_err_count  - bit errors while locked (saturating)
// Options  : RX_BER_CLEAR_EN - when defined, adds the i_clear port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_prbs_sampler #(
  parameter int NB_INPUT = 8,
  parameter int OS       = 4,
  parameter int NB_CNT   = 32,
  parameter int WIN_LEN  = 64,
  parameter int LOSS_THR = 8
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
`ifdef RX_BER_CLEAR_EN
  input  logic                      i_clear,
`endif
  input  logic signed [NB_INPUT-1:0] i_data,
  input  logic [$clog2(OS)-1:0]     i_phase,
  output logic                      o_bit,
  output logic                      o_bit_valid,
  output logic                      o_locked,
  output logic [NB_CNT-1:0]         o_bit_count,
  output logic [NB_CNT-1:0]         o_err_count
);

  // --------------------------------------------------------------------------
  // Local constants
  // --------------------------------------------------------------------------
  localparam int c_PH_W  = $clog2(OS);
  localparam int c_WBC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int c_WEC_W = $clog2(LOSS_THR + 1);

  localparam logic [c_WBC_W-1:0] c_WBC_LAST = c_WBC_W'(WIN_LEN - 1);
  localparam logic [c_WEC_W-1:0] c_WEC_LOSS = c_WEC_W'(LOSS_THR);
  localparam logic [3:0]         c_FILL_LAST = 4'd8;

  // --------------------------------------------------------------------------
  // Decimator / slicer
  // --------------------------------------------------------------------------
  logic [c_PH_W-1:0] ph_q;
  logic              bit_q;
  logic              bit_valid_q;
  logic              w_strobe;
  logic              w_unused_lsbs;

  // Only the sign bit matters to a hard slicer.
  assign w_unused_lsbs = ^i_data[NB_INPUT-2:0];

  // Phase is compared against the live i_phase, so a phase change simply
  // lands on the next matching count without disturbing the counter.
  assign w_strobe = i_enable && (ph_q == i_phase);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      ph_q        <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      bit_valid_q <= w_strobe;
      if (i_enable) begin
        // OS is a power of two, so natural wrap gives mod-OS counting.
        ph_q <= ph_q + 1'b1;
      end
      if (w_strobe) begin
        bit_q <= i_data[NB_INPUT-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // PRBS9 checker
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  state_t              state_q;
  logic [8:0]          lfsr_q;
  logic [3:0]          fill_cnt_q;
  logic [c_WBC_W-1:0]  wbc_q;
  logic [c_WEC_W-1:0]  wec_q;
  logic [NB_CNT-1:0]   bit_cnt_q;
  logic [NB_CNT-1:0]   err_cnt_q;
  logic                locked_q;

  logic                w_consume;
  logic                w_pred;
  logic                w_err;
  logic [c_WEC_W-1:0]  w_wec_d;
  logic [NB_CNT-1:0]   w_bit_cnt_d;
  logic [NB_CNT-1:0]   w_err_cnt_d;

  // A held-off cycle freezes the checker even if a bit is pending.
  assign w_consume = bit_valid_q && i_enable;

  // Next bit predicted by the recurrence b[n] = b[n-9] ^ b[n-5].
  assign w_pred = lfsr_q[8] ^ lfsr_q[4];
  assign w_err  = bit_q ^ w_pred;

  assign w_wec_d = wec_q + {{(c_WEC_W-1){1'b0}}, w_err};

  // Saturating global counters.
  assign w_bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + 1'b1;
  assign w_err_cnt_d = ((&err_cnt_q) || !w_err) ? err_cnt_q : err_cnt_q + 1'b1;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_FILL;
      lfsr_q     <= '0;
      fill_cnt_q <= '0;
      wbc_q      <= '0;
      wec_q      <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      if (w_consume) begin
        case (state_q)
          S_FILL: begin
            // Load received bits directly until the register holds a full
            // history, then switch to free-running prediction.
            lfsr_q <= {lfsr_q[7:0], bit_q};
            if (fill_cnt_q == c_FILL_LAST) begin
              state_q    <= S_CHECK;
              locked_q   <= 1'b1;
              fill_cnt_q <= '0;
              wbc_q      <= '0;
              wec_q      <= '0;
            end else begin
              fill_cnt_q <= fill_cnt_q + 4'd1;
            end
          end
          S_CHECK: begin
            // Free-running on the prediction so one flipped input bit costs
            // exactly one error rather than three.
            lfsr_q    <= {lfsr_q[7:0], w_pred};
            bit_cnt_q <= w_bit_cnt_d;
            err_cnt_q <= w_err_cnt_d;
            if (w_wec_d == c_WEC_LOSS) begin
              // Too many errors in this window: drop lock and refill.
              state_q    <= S_FILL;
              locked_q   <= 1'b0;
              fill_cnt_q <= '0;
              wbc_q      <= '0;
              wec_q      <= '0;
            end else if (wbc_q == c_WBC_LAST) begin
              // Window closed below threshold: start a fresh window.
              wbc_q <= '0;
              wec_q <= '0;
            end else begin
              wbc_q <= wbc_q + 1'b1;
              wec_q <= w_wec_d;
            end
          end
          default: begin
            state_q  <= S_FILL;
            locked_q <= 1'b0;
          end
        endcase
      end
`ifdef RX_BER_CLEAR_EN
      // Clear wins over any increment in the same cycle and ignores
      // i_enable; lock state and LFSR are left alone.
      if (i_clear) begin
        bit_cnt_q <= '0;
        err_cnt_q <= '0;
        wbc_q     <= '0;
        wec_q     <= '0;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_locked    = locked_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_prbs_sampler.sv
// ============================================================================
// Module   : tb_rx_prbs_sampler
// Purpose  : Directed self-checking bench for rx_prbs_sampler (OS=4).
//            Covers reset values, phase selection, PRBS9 lock, isolated
//            errors, loss/reacquire, freeze, asynchronous reset and, when
//            RX_BER_CLEAR_EN is defined, the counter clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_prbs_sampler;

  logic              clock;
  logic              i_reset;
  logic              i_enable;
`ifdef RX_BER_CLEAR_EN
  logic              i_clear;
`endif
  logic signed [7:0] i_data;
  logic [1:0]        i_phase;
  logic              o_bit;
  logic              o_bit_valid;
  logic              o_locked;
  logic [31:0]       o_bit_count;
  logic [31:0]       o_err_count;

  int total;
  int bad;

  logic [8:0] gen;
  logic       cur_bit;
  logic       lk [4];
  logic       vl [4];
  logic       ob [4];

  logic        sv_bit;
  logic [31:0] sv_bcnt;
  logic [31:0] sv_ecnt;

  rx_prbs_sampler #(
    .NB_INPUT (8),
    .OS       (4),
    .NB_CNT   (32),
    .WIN_LEN  (64),
    .LOSS_THR (8)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
`ifdef RX_BER_CLEAR_EN
    .i_clear     (i_clear),
`endif
    .i_data      (i_data),
    .i_phase     (i_phase),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid),
    .o_locked    (o_locked),
    .o_bit_count (o_bit_count),
    .o_err_count (o_err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic step(input logic en, input logic signed [7:0] d);
    i_enable = en;
    i_data   = d;
    @(posedge clock);
    #1;
  endtask

  // Next PRBS9 symbol upsampled x4 (optionally inverted); records the
  // outputs seen after each of its four cycles.
  task automatic send_sym(input logic flip);
    logic b;
    logic signed [7:0] d;
    b   = gen[8] ^ gen[4];
    gen = {gen[7:0], b};
    cur_bit = b ^ flip;
    d = cur_bit ? -8'sd5 : 8'sd5;
    for (int s = 0; s < 4; s++) begin
      step(1'b1, d);
      lk[s] = o_locked;
      vl[s] = o_bit_valid;
      ob[s] = o_bit;
    end
  endtask

  initial begin
    logic signed [7:0] dd;
    total    = 0;
    bad      = 0;
    gen      = 9'h1FF;
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_data   = 8'sd0;
    i_phase  = 2'd0;
`ifdef RX_BER_CLEAR_EN
    i_clear  = 1'b0;
`endif
    #1;
    // ---------------- reset values
    chk("rst_bit",    64'(o_bit),       64'(0));
    chk("rst_valid",  64'(o_bit_valid), 64'(0));
    chk("rst_locked", 64'(o_locked),    64'(0));
    chk("rst_bcnt",   64'(o_bit_count), 64'(0));
    chk("rst_ecnt",   64'(o_err_count), 64'(0));
    repeat (3) @(posedge clock);
    #1;
    i_reset = 1'b1;
    step(1'b0, 8'sd0);
    step(1'b0, 8'sd0);

    // ---------------- phase select: keep phase 2 of {+5,+5,-5,+5}
    i_phase = 2'd2;
    for (int k = 0; k < 12; k++) begin
      dd = ((k % 4) == 2) ? -8'sd5 : 8'sd5;
      step(1'b1, dd);
      chk("phase_valid", 64'(o_bit_valid), 64'(((k % 4) == 2) ? 1 : 0));
      if ((k % 4) == 2) chk("phase_bit", 64'(o_bit), 64'(1));
    end

    // ---------------- reset mid-operation, then acquire lock at phase 0
    i_reset = 1'b0;
    step(1'b0, 8'sd0);
    i_reset = 1'b1;
    i_phase = 2'd0;
    step(1'b0, 8'sd0);

    send_sym(1'b0);
    chk("fill_valid0", 64'(vl[0]), 64'(1));
    chk("fill_bit0",   64'(ob[0]), 64'(cur_bit));
    chk("fill_valid1", 64'(vl[1]), 64'(0));
    for (int n = 1; n < 8; n++) send_sym(1'b0);
    chk("prelock", 64'(lk[3]), 64'(0));
    send_sym(1'b0);                       // 9th fill bit
    chk("lock_at_valid", 64'(lk[0]), 64'(0));
    chk("lock_rise",     64'(lk[1]), 64'(1));
    chk("lock_bcnt0",    64'(o_bit_count), 64'(0));

    repeat (1000) send_sym(1'b0);
    chk("clean_bcnt",   64'(o_bit_count), 64'(1000));
    chk("clean_ecnt",   64'(o_err_count), 64'(0));
    chk("clean_locked", 64'(o_locked),    64'(1));

    // ---------------- three isolated errors in one window
    for (int j = 0; j < 20; j++) send_sym((j == 2) || (j == 8) || (j == 14));
    chk("err3_ecnt",   64'(o_err_count), 64'(3));
    chk("err3_bcnt",   64'(o_bit_count), 64'(1020));
    chk("err3_locked", 64'(o_locked),    64'(1));
    repeat (4) send_sym(1'b0);            // close the window at 1024 bits
    chk("win_bcnt", 64'(o_bit_count), 64'(1024));

    // ---------------- eight errors in one window -> loss of lock
    for (int j = 0; j < 14; j++) send_sym((j % 2) == 0);
    chk("loss7_locked", 64'(o_locked), 64'(1));
    send_sym(1'b1);                       // 8th error
    chk("loss_at_valid", 64'(lk[0]), 64'(1));
    chk("loss_fall",     64'(lk[1]), 64'(0));
    chk("loss_ecnt",     64'(o_err_count), 64'(11));
    chk("loss_bcnt",     64'(o_bit_count), 64'(1039));
    for (int j = 0; j < 8; j++) send_sym(1'b0);
    chk("refill_locked", 64'(lk[3]), 64'(0));
    chk("refill_bcnt",   64'(o_bit_count), 64'(1039));
    send_sym(1'b0);
    chk("relock_at_valid", 64'(lk[0]), 64'(1'b0));
    chk("relock_rise",     64'(lk[1]), 64'(1));
    repeat (10) send_sym(1'b0);
    chk("relock_bcnt", 64'(o_bit_count), 64'(1049));
    chk("relock_ecnt", 64'(o_err_count), 64'(11));

    // ---------------- freeze for 20 cycles
    sv_bit  = o_bit;
    sv_bcnt = o_bit_count;
    sv_ecnt = o_err_count;
    for (int j = 0; j < 20; j++) step(1'b0, ((j % 2) == 0) ? -8'sd7 : 8'sd7);
    chk("frz_valid",  64'(o_bit_valid), 64'(0));
    chk("frz_bit",    64'(o_bit),       64'(sv_bit));
    chk("frz_locked", 64'(o_locked),    64'(1));
    chk("frz_bcnt",   64'(o_bit_count), 64'(sv_bcnt));
    chk("frz_ecnt",   64'(o_err_count), 64'(sv_ecnt));
    repeat (5) send_sym(1'b0);
    chk("resume_bcnt",   64'(o_bit_count), 64'(1054));
    chk("resume_ecnt",   64'(o_err_count), 64'(11));
    chk("resume_locked", 64'(o_locked),    64'(1));

    // ---------------- asynchronous reset between edges
    step(1'b1, -8'sd5);                   // strobe at phase 0 -> bit 1
    chk("pre_rst_valid", 64'(o_bit_valid), 64'(1));
    chk("pre_rst_bit",   64'(o_bit),       64'(1));
    #2;
    i_reset = 1'b0;
    #1;
    chk("arst_bit",    64'(o_bit),       64'(0));
    chk("arst_valid",  64'(o_bit_valid), 64'(0));
    chk("arst_locked", 64'(o_locked),    64'(0));
    chk("arst_bcnt",   64'(o_bit_count), 64'(0));
    chk("arst_ecnt",   64'(o_err_count), 64'(0));
    step(1'b0, 8'sd0);
    i_reset = 1'b1;
    step(1'b0, 8'sd0);

`ifdef RX_BER_CLEAR_EN
    // ---------------- synchronous clear while locked
    repeat (9) send_sym(1'b0);
    chk("clr_lock", 64'(o_locked), 64'(1));
    repeat (500) send_sym(1'b0);
    chk("clr_pre_bcnt", 64'(o_bit_count), 64'(500));
    i_clear = 1'b1;
    step(1'b0, 8'sd0);
    i_clear = 1'b0;
    chk("clr_bcnt",   64'(o_bit_count), 64'(0));
    chk("clr_ecnt",   64'(o_err_count), 64'(0));
    chk("clr_locked", 64'(o_locked),    64'(1));
    repeat (10) send_sym(1'b0);
    chk("clr_resume_bcnt", 64'(o_bit_count), 64'(10));
    chk("clr_resume_ecnt", 64'(o_err_count), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
